// File: rtl/pyramid_sum_arbiter_if.sv
// pyramid_sum_arbiter_if: request, adder and result stream signals of the shared pyramid-sum arbiter
interface pyramid_sum_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 3,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ*SIZE*WIDTH-1:0] req_tdata;
  logic [NREQ-1:0]            req_tvalid;
  logic [NREQ-1:0]            req_tready;
  logic [SIZE*WIDTH-1:0]      add_tdata;
  logic                       add_tvalid;
  logic                       add_tready;
  logic [WIDTH-1:0]           sum_tdata;
  logic [WIDTH-1:0]           o_tdata;
  logic [IDW-1:0]             o_tid;
  logic                       o_tvalid;
  logic                       o_tready;
  logic                       busy;
  modport slave (
    input  req_tdata, req_tvalid, sum_tdata, o_tready,
    output req_tready, add_tdata, add_tvalid, add_tready, o_tdata, o_tid, o_tvalid, busy
  );
  modport master (
    output req_tdata, req_tvalid, sum_tdata, o_tready,
    input  req_tready, add_tdata, add_tvalid, add_tready, o_tdata, o_tid, o_tvalid, busy
  );
endinterface

// File: rtl/pyramid_sum_arbiter.sv
// pyramid_sum_arbiter: round-robin sharing of one pipelined adder tree with requester-ID tag tracking
module pyramid_sum_arbiter #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 3,
  parameter int NREQ    = 4,
  parameter int LATENCY = 2,
  parameter int IDW     = 2
) (
  input logic clk,
  input logic reset_n,
  pyramid_sum_arbiter_if.slave bus
);
  logic                  adv;
  logic                  granted;
  logic [IDW-1:0]        g;
  logic [IDW-1:0]        idx;
  logic [SIZE*WIDTH-1:0] add_data;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [IDW-1:0]        id_q [LATENCY];
  logic [IDW-1:0]        id_d [LATENCY];
  assign adv = ~bus.o_tvalid | bus.o_tready;
  always_comb begin
    granted  = 1'b0;
    g        = last_grant_q;
    idx      = '0;
    add_data = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_grant_q) + i) % NREQ);
      if (!granted && bus.req_tvalid[idx]) begin
        granted = 1'b1;
        g       = idx;
      end
    end
    for (int r = 0; r < NREQ; r++)
      add_data = (granted && g == IDW'(r)) ? bus.req_tdata[r*SIZE*WIDTH +: SIZE*WIDTH] : add_data;
  end
  always_comb begin
    last_grant_d = (adv && granted) ? g : last_grant_q;
    vld_d        = vld_q;
    id_d         = id_q;
    if (adv) begin
      vld_d[0] = granted;
      id_d[0]  = g;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
      end
    end
  end
  // stale adder contents after reset are masked by the cleared tag valids
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= IDW'(NREQ - 1);
      vld_q        <= '0;
      id_q         <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      vld_q        <= vld_d;
      id_q         <= id_d;
    end
  end
  assign bus.req_tready = NREQ'(adv & granted) << g;
  assign bus.add_tdata  = add_data;
  assign bus.add_tvalid = adv;
  assign bus.add_tready = adv;
  assign bus.o_tvalid   = vld_q[LATENCY-1];
  assign bus.o_tid      = id_q[LATENCY-1];
  assign bus.o_tdata    = bus.sum_tdata;
  assign bus.busy       = |vld_q;
endmodule
